// File: rtl/xadc_scan_bcd.sv
// Round-robin XADC DRP scanner: averages samples per channel, scales them to millivolts
// and presents the switch-selected channel as BCD digits, a thermometer bar and a timeout flag.
module xadc_scan_bcd #(
    parameter int                    NUM_CH        = 4,
    parameter logic [7*NUM_CH-1:0]   ADDR_LIST     = {7'h1f, 7'h1e, 7'h17, 7'h16},
    parameter int                    AVG_LOG2      = 2,
    parameter int                    FULL_SCALE_MV = 1000,
    parameter int                    DIGITS        = 4,
    parameter int                    TIMEOUT       = 255
) (
    input  logic                  CLK100MHZ,
    input  logic                  resetn,
    input  logic                  eoc,
    input  logic                  drdy,
    input  logic [15:0]           do_in,
    input  logic [2:0]            sel,
    output logic [6:0]            daddr,
    output logic                  den,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  bcd_valid,
    output logic [15:0]           bar,
    output logic                  timeout_err
);

    localparam int CHW  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int AW   = 12 + AVG_LOG2;
    localparam int CNTW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int TMW  = $clog2(TIMEOUT + 1);
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'((1 << AVG_LOG2) - 1);
    localparam logic [TMW-1:0]  TMO_LAST = TMW'(TIMEOUT - 1);
    localparam logic [CHW-1:0]  CH_LAST  = CHW'(NUM_CH - 1);

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_ACC, S_NEXT} scanState_t;
    typedef enum logic [1:0] {B_IDLE, B_LOAD, B_SHIFT, B_COMMIT} bcdState_t;

    scanState_t          r_scan, w_scanNext;
    logic [CHW-1:0]      r_ch, w_chNext;
    logic [TMW-1:0]      r_tmo;
    logic                w_tmoHit;
    logic [11:0]         r_code;
    logic                r_den;
    logic [6:0]          r_daddr, w_addrNext;
    logic                r_tmoErr;

    logic [AW-1:0]       r_acc [NUM_CH];
    logic [CNTW-1:0]     r_cnt [NUM_CH];
    logic [11:0]         r_avg [NUM_CH];
    logic                r_have [NUM_CH];
    logic [15:0]         r_mv [NUM_CH];
    logic                r_upd, r_mvUpd;
    logic [CHW-1:0]      r_updCh, r_mvCh;
    logic [AW-1:0]       w_sum;
    logic [11:0]         w_avgNew;
    logic                w_cntFull;
    logic [29:0]         w_prod;
    logic [17:0]         w_scaled;
    logic [15:0]         w_mvScaled;

    bcdState_t           r_bst, w_bcdNext;
    logic [CHW-1:0]      w_effSel, r_selPrev, r_convCh;
    logic                w_selChg, w_trig, r_pend;
    logic [15:0]         r_bin;
    logic [18:0]         r_conv, w_convShift;
    logic [15:0]         w_adj;
    logic [3:0]          r_shCnt;
    logic [4*DIGITS-1:0] r_bcd, w_res;
    logic                r_bcdValid;
    logic [4:0]          w_barN;
    logic [15:0]         w_bar, r_bar;
    logic                w_unused;

    assign w_unused = ^do_in[3:0];

    always_comb begin
        w_scanNext = r_scan;
        w_chNext   = r_ch;
        w_tmoHit   = 1'b0;
        case (r_scan)
            S_IDLE: begin
                if (eoc) begin
                    w_scanNext = S_REQ;
                    w_chNext   = '0;
                end
            end
            S_REQ:  w_scanNext = S_WAIT;
            S_WAIT: begin
                if (drdy) begin
                    w_scanNext = S_ACC;
                end else if (r_tmo == TMO_LAST) begin
                    w_scanNext = S_NEXT;
                    w_tmoHit   = 1'b1;
                end
            end
            S_ACC:  w_scanNext = S_NEXT;
            S_NEXT: begin
                if (r_ch == CH_LAST) begin
                    w_scanNext = S_IDLE;
                    w_chNext   = '0;
                end else begin
                    w_scanNext = S_REQ;
                    w_chNext   = r_ch + 1'b1;
                end
            end
            default: w_scanNext = S_IDLE;
        endcase
    end

    always_comb begin
        w_addrNext = ADDR_LIST[6:0];
        for (int i = 0; i < NUM_CH; i++) begin
            if (w_chNext == CHW'(i)) begin
                w_addrNext = ADDR_LIST[7*i +: 7];
            end
        end
    end

    // den and daddr are registered off the next state so den is high exactly for the REQ cycle
    always_ff @(posedge CLK100MHZ or negedge resetn) begin
        if (!resetn) begin
            r_scan   <= S_IDLE;
            r_ch     <= '0;
            r_tmo    <= '0;
            r_code   <= '0;
            r_den    <= 1'b0;
            r_daddr  <= ADDR_LIST[6:0];
            r_tmoErr <= 1'b0;
        end else begin
            r_scan <= w_scanNext;
            r_ch   <= w_chNext;
            r_den  <= (w_scanNext == S_REQ);
            if (w_scanNext == S_REQ) begin
                r_daddr <= w_addrNext;
            end
            r_tmo <= (r_scan == S_WAIT) ? r_tmo + 1'b1 : '0;
            if (r_scan == S_WAIT && drdy) begin
                r_code <= do_in[15:4];
            end
            if (w_tmoHit) begin
                r_tmoErr <= 1'b1;
            end
        end
    end

    always_comb begin
        w_sum      = r_acc[r_ch] + AW'(r_code);
        w_avgNew   = 12'(w_sum >> AVG_LOG2);
        w_cntFull  = (r_cnt[r_ch] == CNT_LAST);
        w_prod     = 30'(r_avg[r_updCh]) * 30'(FULL_SCALE_MV) + 30'd2048;
        w_scaled   = 18'(w_prod >> 12);
        w_mvScaled = (w_scaled > 18'(FULL_SCALE_MV)) ? 16'(FULL_SCALE_MV) : w_scaled[15:0];
    end

    // Averaging, then millivolt scaling one cycle after a channel's average is published
    always_ff @(posedge CLK100MHZ or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_acc[i]  <= '0;
                r_cnt[i]  <= '0;
                r_avg[i]  <= '0;
                r_have[i] <= 1'b0;
                r_mv[i]   <= '0;
            end
            r_upd   <= 1'b0;
            r_updCh <= '0;
            r_mvUpd <= 1'b0;
            r_mvCh  <= '0;
        end else begin
            r_upd <= 1'b0;
            if (r_scan == S_ACC) begin
                if (w_cntFull) begin
                    r_acc[r_ch]  <= '0;
                    r_cnt[r_ch]  <= '0;
                    r_avg[r_ch]  <= w_avgNew;
                    r_have[r_ch] <= 1'b1;
                    r_upd        <= 1'b1;
                    r_updCh      <= r_ch;
                end else begin
                    r_acc[r_ch] <= w_sum;
                    r_cnt[r_ch] <= r_cnt[r_ch] + 1'b1;
                end
            end
            r_mvUpd <= r_upd;
            if (r_upd) begin
                r_mv[r_updCh] <= w_mvScaled;
                r_mvCh        <= r_updCh;
            end
        end
    end

    assign w_effSel = ({1'b0, sel} >= 4'(NUM_CH)) ? CH_LAST : CHW'(sel);
    assign w_selChg = (w_effSel != r_selPrev);
    assign w_trig   = (r_mvUpd && (r_mvCh == w_effSel)) || w_selChg;

    always_comb begin
        w_bcdNext = r_bst;
        case (r_bst)
            B_IDLE:   if (w_trig) w_bcdNext = B_LOAD;
            B_LOAD:   w_bcdNext = B_SHIFT;
            B_SHIFT:  if (r_shCnt == 4'd15) w_bcdNext = B_COMMIT;
            B_COMMIT: w_bcdNext = (r_pend || w_trig) ? B_LOAD : B_IDLE;
            default:  w_bcdNext = B_IDLE;
        endcase
    end

    // The ten-thousands digit never exceeds 6, so only the lower four digits need add-3
    always_comb begin
        w_adj = r_conv[15:0];
        for (int d = 0; d < 4; d++) begin
            if (r_conv[4*d +: 4] >= 4'd5) begin
                w_adj[4*d +: 4] = r_conv[4*d +: 4] + 4'd3;
            end
        end
        w_convShift = {r_conv[17:16], w_adj, r_bin[15]};
    end

    generate
        if (DIGITS == 4) begin : g_four
            assign w_res = (r_conv[18:16] != 3'd0) ? {DIGITS{4'h9}} : r_conv[15:0];
        end else begin : g_five
            assign w_res = {1'b0, r_conv};
        end
    endgenerate

    // A trigger during a running conversion leaves one pending rerun with the latest data
    always_ff @(posedge CLK100MHZ or negedge resetn) begin
        if (!resetn) begin
            r_bst      <= B_IDLE;
            r_bin      <= '0;
            r_conv     <= '0;
            r_shCnt    <= '0;
            r_pend     <= 1'b0;
            r_convCh   <= '0;
            r_bcd      <= '0;
            r_bcdValid <= 1'b0;
            r_selPrev  <= '0;
        end else begin
            r_bst     <= w_bcdNext;
            r_selPrev <= w_effSel;
            if (r_bst == B_COMMIT) begin
                r_pend <= 1'b0;
            end else if (r_bst != B_IDLE && w_trig) begin
                r_pend <= 1'b1;
            end
            case (r_bst)
                B_LOAD: begin
                    r_bin    <= r_mv[w_effSel];
                    r_convCh <= w_effSel;
                    r_conv   <= '0;
                    r_shCnt  <= '0;
                end
                B_SHIFT: begin
                    r_conv  <= w_convShift;
                    r_bin   <= {r_bin[14:0], 1'b0};
                    r_shCnt <= r_shCnt + 1'b1;
                end
                B_COMMIT: begin
                    r_bcd      <= w_res;
                    r_bcdValid <= r_have[r_convCh];
                end
                default: ;
            endcase
            if (w_selChg && !r_have[w_effSel]) begin
                r_bcdValid <= 1'b0;
            end
        end
    end

    assign w_barN = {1'b0, r_avg[w_effSel][11:8]} + 5'd1;
    assign w_bar  = 16'hFFFF >> (5'd16 - w_barN);

    always_ff @(posedge CLK100MHZ or negedge resetn) begin
        if (!resetn) begin
            r_bar <= '0;
        end else begin
            r_bar <= r_have[w_effSel] ? w_bar : '0;
        end
    end

    assign daddr       = r_daddr;
    assign den         = r_den;
    assign bcd         = r_bcd;
    assign bcd_valid   = r_bcdValid;
    assign bar         = r_bar;
    assign timeout_err = r_tmoErr;

endmodule

// File: tb/tb_xadc_scan_bcd.sv
// Directed bench for xadc_scan_bcd: a small DRP responder model answers den pulses,
// and hand-computed millivolt/BCD/bar values are checked per scenario.
module tb_xadc_scan_bcd;

    logic        CLK100MHZ = 1'b0;
    logic        resetn;
    logic        eoc;
    logic        drdy;
    logic [15:0] do_in;
    logic [2:0]  sel;
    logic [6:0]  daddr;
    logic        den;
    logic [15:0] bcd;
    logic        bcd_valid;
    logic [15:0] bar;
    logic        timeout_err;

    int          vecCount  = 0;
    int          missCount = 0;
    int          denCount  = 0;
    logic        denDouble = 1'b0;
    logic [6:0]  addrLog[$];
    logic [11:0] chCode[4];
    logic        silent[4];
    logic [6:0]  expAddr[4];

    always #5 CLK100MHZ = ~CLK100MHZ;

    xadc_scan_bcd dut (
        .CLK100MHZ   (CLK100MHZ),
        .resetn      (resetn),
        .eoc         (eoc),
        .drdy        (drdy),
        .do_in       (do_in),
        .sel         (sel),
        .daddr       (daddr),
        .den         (den),
        .bcd         (bcd),
        .bcd_valid   (bcd_valid),
        .bar         (bar),
        .timeout_err (timeout_err)
    );

    function automatic int chOf(input logic [6:0] a);
        case (a)
            7'h16:   return 0;
            7'h17:   return 1;
            7'h1E:   return 2;
            default: return 3;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vecCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK100MHZ);
            #1;
        end
    endtask

    task automatic waitDen(input int target, input int budget, input string tag);
        int n;
        n = 0;
        while (denCount < target && n < budget) begin
            tick(1);
            n++;
        end
        checkOutput(tag, 32'(denCount >= target), 32'd1);
    endtask

    // One eoc pulse, then wait for the full scan and the downstream BCD pipeline to settle
    task automatic applyStimulus(input int budget);
        int base;
        base = denCount;
        eoc = 1'b1;
        tick(1);
        eoc = 1'b0;
        waitDen(base + 4, budget, "scanDone");
        tick(40);
    endtask

    // DRP responder: drdy three cycles after den, silent channels never answer
    initial begin
        logic [6:0] a;
        int c;
        drdy  = 1'b0;
        do_in = 16'h0000;
        forever begin
            @(negedge CLK100MHZ);
            if (den === 1'b1) begin
                a = daddr;
                c = chOf(a);
                addrLog.push_back(a);
                if (!silent[c]) begin
                    repeat (3) @(negedge CLK100MHZ);
                    do_in = {chCode[c], (c == 0) ? 4'h0 : 4'h5};
                    drdy  = 1'b1;
                    @(negedge CLK100MHZ);
                    drdy  = 1'b0;
                    do_in = 16'h0000;
                end
            end
        end
    end

    initial begin
        logic prevDen;
        prevDen = 1'b0;
        forever begin
            @(negedge CLK100MHZ);
            if (den === 1'b1) begin
                denCount++;
                if (prevDen) denDouble = 1'b1;
            end
            prevDen = den;
        end
    end

    initial begin
        #1ms;
        $display("[TB] FAIL watchdog: simulation did not finish, vectors=%0d", vecCount);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int base;
        logic [15:0] first;
        expAddr = '{7'h16, 7'h17, 7'h1E, 7'h1F};
        chCode  = '{12'hFFF, 12'd2000, 12'h800, 12'h400};
        silent  = '{1'b0, 1'b0, 1'b0, 1'b0};
        sel     = 3'd0;
        eoc     = 1'b0;
        resetn  = 1'b0;
        tick(3);
        checkOutput("rstDaddr", 32'(daddr), 32'h16);
        checkOutput("rstDen", 32'(den), 32'd0);
        checkOutput("rstBcd", 32'(bcd), 32'h0);
        checkOutput("rstValid", 32'(bcd_valid), 32'd0);
        checkOutput("rstBar", 32'(bar), 32'h0);
        checkOutput("rstTmo", 32'(timeout_err), 32'd0);
        resetn = 1'b1;
        tick(2);

        // Four scans: ch1 averages 2000,2004,2008,2012 -> 2006 -> 490 mV
        sel = 3'd1;
        for (int k = 0; k < 4; k++) begin
            chCode[1] = 12'(2000 + 4 * k);
            base = addrLog.size();
            applyStimulus(600);
            if (k == 0) begin
                for (int i = 0; i < 4; i++) begin
                    checkOutput($sformatf("scanAddr%0d", i), 32'(addrLog[base + i]), 32'(expAddr[i]));
                end
            end
            if (k < 3) begin
                checkOutput($sformatf("earlyBcd%0d", k), 32'(bcd), 32'h0);
                checkOutput($sformatf("earlyValid%0d", k), 32'(bcd_valid), 32'd0);
            end
        end
        checkOutput("ch1Bcd", 32'(bcd), 32'h0490);
        checkOutput("ch1Valid", 32'(bcd_valid), 32'd1);
        checkOutput("ch1Bar", 32'(bar), 32'h00FF);

        sel = 3'd0;
        tick(25);
        checkOutput("ch0Bcd", 32'(bcd), 32'h1000);
        checkOutput("ch0Bar", 32'(bar), 32'hFFFF);
        checkOutput("ch0Valid", 32'(bcd_valid), 32'd1);
        sel = 3'd2;
        tick(25);
        checkOutput("ch2Bcd", 32'(bcd), 32'h0500);
        checkOutput("ch2Bar", 32'(bar), 32'h01FF);
        sel = 3'd5;
        tick(25);
        checkOutput("sel5Bcd", 32'(bcd), 32'h0250);
        checkOutput("sel5Bar", 32'(bar), 32'h001F);
        checkOutput("noTmoYet", 32'(timeout_err), 32'd0);

        // Switch ch1 -> ch0 -> ch2 while the ch0 conversion is still shifting
        sel = 3'd1;
        tick(25);
        sel = 3'd0;
        tick(5);
        sel = 3'd2;
        first = bcd;
        for (int n = 0; n < 30 && bcd == 16'h0490; n++) tick(1);
        first = bcd;
        checkOutput("selSwitchFirst", 32'(first), 32'h1000);
        for (int n = 0; n < 18 && bcd == first; n++) tick(1);
        checkOutput("selSwitchSecond", 32'(bcd), 32'h0500);

        // ch2 never answers: timeout flagged, scan still reaches ch3, ch2 value kept
        silent[2] = 1'b1;
        base = addrLog.size();
        applyStimulus(2000);
        checkOutput("tmoFlag", 32'(timeout_err), 32'd1);
        checkOutput("tmoNextAddr", 32'(addrLog[base + 3]), 32'h1F);
        checkOutput("tmoCh2Bcd", 32'(bcd), 32'h0500);
        silent[2] = 1'b0;

        // eoc held high for a whole scan must not start extra requests
        base = denCount;
        eoc = 1'b1;
        waitDen(base + 4, 500, "stormDone");
        eoc = 1'b0;
        tick(40);
        checkOutput("stormDenCount", 32'(denCount - base), 32'd4);
        checkOutput("denOverlap", 32'(denDouble), 32'd0);

        // Reset while waiting on the ch1 read
        base = denCount;
        eoc = 1'b1;
        tick(1);
        eoc = 1'b0;
        waitDen(base + 2, 200, "preResetDen");
        resetn = 1'b0;
        #2;
        checkOutput("midRstDaddr", 32'(daddr), 32'h16);
        checkOutput("midRstDen", 32'(den), 32'd0);
        checkOutput("midRstBcd", 32'(bcd), 32'h0);
        checkOutput("midRstValid", 32'(bcd_valid), 32'd0);
        checkOutput("midRstBar", 32'(bar), 32'h0);
        checkOutput("midRstTmo", 32'(timeout_err), 32'd0);
        tick(3);
        resetn = 1'b1;
        tick(10);
        base = addrLog.size();
        applyStimulus(600);
        checkOutput("postRstFirstAddr", 32'(addrLog[base]), 32'h16);
        checkOutput("postRstBar", 32'(bar), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule

// File: doc/xadc_scan_bcd.md
Name: xadc_scan_bcd

Overview:
- Multi-channel successor to the single-address XADC DMM readout.
- Drives the XADC DRP port round-robin over NUM_CH channel addresses, starting one pass per end-of-conversion pulse.
- Averages 2^AVG_LOG2 samples per channel and scales each average to millivolts.
- Presents the switch-selected channel as BCD digits for the 7-segment driver, plus an LED thermometer bar and a DRP timeout flag.

Parameters:
- NUM_CH, 4, number of scanned channels (1..8).
- ADDR_LIST, {7'h1f,7'h1e,7'h17,7'h16}, packed 7-bit DRP addresses; channel i is bits [7i+6:7i].
- AVG_LOG2, 2, log2 of samples averaged per channel (0..4).
- FULL_SCALE_MV, 1000, millivolt value of code 4096 (max 65535).
- DIGITS, 4, BCD digits output (4..5).
- TIMEOUT, 255, max cycles from den to drdy before the read is abandoned.

Ports:
- CLK100MHZ  in  1  system clock; all logic on its rising edge.
- resetn  in  1  asynchronous active-low reset.
- eoc  in  1  XADC eoc_out; one-cycle pulse per conversion.
- drdy  in  1  XADC drdy_out.
- do_in  in  16  XADC do_out; the code is do_in[15:4].
- sel  in  3  display channel select; values >= NUM_CH are treated as NUM_CH-1.
- daddr  out  7  DRP address to XADC.
- den  out  1  DRP enable, one-cycle pulse.
- bcd  out  4*DIGITS  millivolts of the selected channel; digit 0 is in [3:0].
- bcd_valid  out  1  high once the first conversion of the selected channel has completed.
- bar  out  16  thermometer: (avg[11:8]+1) LSB-aligned ones.
- timeout_err  out  1  sticky; set on any DRP timeout.

Behaviour:
- Reset values:
  - daddr = ADDR_LIST[0]; den, bcd, bcd_valid, bar and timeout_err = 0.
  - All accumulators, sample counters and stored results = 0; FSM = IDLE; channel index = 0.
- Scan FSM:
  - IDLE: on eoc=1, go to REQ with ch=0. eoc in any other state is ignored (no queueing).
  - REQ: daddr=ADDR_LIST[ch], den=1 for exactly this cycle; go to WAIT. daddr is held until the next REQ.
  - WAIT: on drdy=1, capture do_in[15:4] and go to ACC. If TIMEOUT cycles elapse without drdy, set timeout_err, skip the accumulate, and go to NEXT.
  - ACC: acc[ch] += code (width 12+AVG_LOG2); cnt[ch]++. When cnt[ch] wraps to 0 (2^AVG_LOG2 samples taken): avg[ch] = acc>>AVG_LOG2, acc[ch] cleared, upd[ch] pulsed.
  - NEXT: ch = ch+1; if ch == NUM_CH-1, go to IDLE with ch=0, else go to REQ.
  - drdy outside WAIT is ignored.
- Scaling, one pipeline register after upd:
  - mv = (avg*FULL_SCALE_MV + 2048) >> 12, clamped to FULL_SCALE_MV.
  - Default values: avg 4095 -> 1000; avg 2048 -> 500; avg 0 -> 0.
- BCD conversion:
  - Sequential double-dabble, one mv bit per cycle, 16 shift cycles plus 1 load and 1 commit; bcd updates atomically at commit.
  - A conversion starts when upd fires for the selected channel, or when the effective sel changes.
  - If a new trigger arrives during a conversion, the running conversion finishes and commits, then one more conversion runs with the latest data. Only a single pending flag is kept; no queue.
  - If mv > 10^DIGITS-1, every digit reads 9.
  - bcd_valid rises at the first commit after the selected channel has at least one avg. It drops to 0 when sel changes to a channel with no avg yet.
- bar: recomputed from avg[sel] every cycle, registered, 1-cycle latency. It remains 0 until the first avg of the selected channel is available.
- Latency, eoc to den: 1 cycle.
- Reset mid-scan: everything returns to reset values immediately; no partial accumulate is retained.

Test Plan:
- NUM_CH=4, AVG_LOG2=0, model returns drdy 3 cycles after den with do_in=16'hFFF0 on ch0; sel=0 -> den pulses carry daddr 16,17,1E,1F in order; bcd=16'h1000, bar=16'hFFFF, bcd_valid=1.
- AVG_LOG2=2, ch1 codes 2000,2004,2008,2012 over 4 scans, sel=1 -> avg 2006; bcd=16'h0490 (mv 490) after the 4th scan, unchanged after scans 1-3.
- DRP model never asserts drdy for ch2 -> after 255 cycles timeout_err=1; scan continues to ch3; ch2 result unchanged; no hang.
- eoc pulsed every cycle during a scan -> exactly NUM_CH den pulses per scan, no overlap, den never high two consecutive cycles.
- sel switched 0->1 mid-conversion with ch1 holding 500 mV -> bcd first commits the ch0 value, then 16'h0500 within 18 cycles; sel=5 displays ch3.
- resetn asserted low in WAIT, then released -> all outputs 0, daddr=7'h16; the next eoc starts at ch0.
